scene_sequencer: RTL and testbench
==================================

# scene_sequencer

Parametrised timed scene sequencer for the VGA front end. It steps a scene index through N_SCENES values at a fixed cycle period, in one of four modes: wrap, ping-pong, one-shot and freeze. Changes can be deferred to the first pixel of a frame so the renderer never tears mid-frame. The start/title screen and the game-over screen read `state` to pick artwork, and use `scene_change` to restart their animation.

## Interface
- N_SCENES, 4: number of scenes; legal range 2..2^SCENE_W.
- SCENE_W, 2: width of `state`.
- PERIOD, 25000000: enabled clock cycles per scene; must be ≥ 2.
- CNT_W, 30: period counter width; 2^CNT_W > PERIOD.
- RESET_SCENE, 2: scene after reset or restart; must be < N_SCENES.
- FRAME_SYNC, 1: 1 = apply advances only at frame start; 0 = apply immediately.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- h_cnt  in  10  current pixel column from the VGA controller.
- v_cnt  in  10  current pixel row from the VGA controller.
- enable  in  1  period counter runs while high.
- mode  in  2  00 wrap, 01 ping-pong, 10 one-shot, 11 freeze.
- skip  in  1  single-cycle pulse; request an advance now.
- restart  in  1  single-cycle pulse; return to RESET_SCENE.
- state  out  SCENE_W  current scene index.
- scene_change  out  1  one-cycle pulse in the cycle after `state` changes.
- done  out  1  one-shot mode has reached its final scene.

## Operation
- Registers: `cnt` (CNT_W bits), `state`, `pending` (an advance has been requested but not yet applied), `dir` (0 = up, 1 = down), `scene_change`.
- Reset values (asynchronous): cnt=0, state=RESET_SCENE, pending=0, dir=0, scene_change=0. `done` is combinational: `done = (mode==10) && (state==N_SCENES-1)`.
- Period counter:
  - Counts when `enable` is high and mode ≠ 11; otherwise it holds.
  - When cnt==PERIOD-1 and counting: cnt←0 and an expiry event is raised.
  - The period is exactly PERIOD enabled cycles.
- Advance request: an expiry or a `skip` (mode ≠ 11) sets `pending`. A `skip` also clears cnt. Several requests while `pending` is already 1 still produce only one advance.
- Apply condition:
  - FRAME_SYNC=0: apply whenever a request is raised this cycle or `pending` is 1.
  - FRAME_SYNC=1: same, but only in a cycle where h_cnt==0 and v_cnt==0 are sampled. A request raised in that same cycle is applied in that cycle.
  - Applying clears `pending`.
- Next-scene rule, s = current state:
  - wrap: s==N_SCENES-1 → 0; otherwise s+1.
  - ping-pong, dir=0: s==N_SCENES-1 → s-1 and dir←1; otherwise s+1.
  - ping-pong, dir=1: s==0 → 1 and dir←0; otherwise s-1.
  - one-shot: s==N_SCENES-1 → hold (no change, no pulse); otherwise s+1.
  - freeze: no advance; `pending` holds its value.
- `dir` changes only in ping-pong mode. A `mode` change takes effect at the next apply and never alters `state` by itself.
- restart:
  - Sets state=RESET_SCENE, cnt=0, pending=0, dir=0. No `scene_change` pulse.
  - Priority: restart > skip > expiry in the same cycle.
- `scene_change` is registered: it is 1 for exactly one cycle after any edge where `state` took a new value by an apply.
- `h_cnt` and `v_cnt` are ignored when FRAME_SYNC=0.

## Timing
- FRAME_SYNC=0: `state` updates on the same edge where cnt goes PERIOD-1→0. `scene_change` is high in the cycle following that edge, at the same time as the new `state` is visible.
- FRAME_SYNC=1: worst-case latency from expiry to a `state` update is one frame of h_cnt/v_cnt scan.
- `skip` with FRAME_SYNC=0: `state` updates on the edge that samples `skip`.
- Asserting `rst` mid-period or mid-pending forces all reset values immediately, without waiting for a clock edge. Deassertion is used synchronously.
- `enable` low freezes cnt but does not cancel `pending`. With FRAME_SYNC=1, a pending advance is still applied at the next frame start.

## Test plan
- Wrap, reset: PERIOD=4, FRAME_SYNC=0, N_SCENES=4, enable=1, mode=00; pulse rst → state=2 immediately. State must read 3 after 4 cycles, 0 after 8, 1 after 12, with one `scene_change` pulse each time.
- Ping-pong: same settings, mode=01 → state sequence 2,3,2,1,0,1 at 4-cycle spacing; `dir` flips at 3 and at 0.
- One-shot: mode=10 → 2 then 3 with `done`=1. State holds at 3 with no further `scene_change` over 20 cycles. Pulse restart → state=2, `done`=0.
- Frame sync: FRAME_SYNC=1, PERIOD=4; drive h_cnt/v_cnt so frame start occurs 10 cycles after expiry → state changes only on the frame-start edge. Two expiries inside one frame → a single advance.
- Priority and freeze: skip and restart in the same cycle → state=2, cnt=0, no pulse. With mode=11, skip and 50 cycles → state unchanged and cnt frozen.
- Async reset: assert rst between clock edges while `pending`=1 → state=2 and pending=0 before the next edge; no advance after release until a full PERIOD has elapsed.

Source files
------------

// File: rtl/scene_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : scene_sequencer_if
//  Description : Control/status bundle between the VGA front end and the
//                scene sequencer (pixel position, mode controls, scene out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface scene_sequencer_if #(
  parameter int SCENE_W = 2
);
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               enable;
  logic [1:0]         mode;
  logic               skip;
  logic               restart;
  logic [SCENE_W-1:0] state;
  logic               scene_change;
  logic               done;

  // Controller side: drives position and controls, observes the scene
  modport master (
    output h_cnt, v_cnt, enable, mode, skip, restart,
    input  state, scene_change, done
  );

  // Sequencer side
  modport slave (
    input  h_cnt, v_cnt, enable, mode, skip, restart,
    output state, scene_change, done
  );
endinterface
`default_nettype wire

// File: rtl/scene_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scene_sequencer
//  Description : Timed scene index stepper with wrap / ping-pong / one-shot /
//                freeze modes and optional deferral of advances to the first
//                pixel of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module scene_sequencer #(
  parameter int N_SCENES    = 4,
  parameter int SCENE_W     = 2,
  parameter int PERIOD      = 25000000,
  parameter int CNT_W       = 30,
  parameter int RESET_SCENE = 2,
  parameter int FRAME_SYNC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  scene_sequencer_if.slave  bus
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_PING    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_FREEZE  = 2'b11;

  localparam logic [SCENE_W-1:0] LAST_SCENE  = SCENE_W'(N_SCENES - 1);
  localparam logic [SCENE_W-1:0] FIRST_SCENE = '0;
  localparam logic [SCENE_W-1:0] RST_SCENE   = SCENE_W'(RESET_SCENE);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [SCENE_W-1:0] state_q, state_d;
  logic               pending_q, pending_d;
  logic               dir_q, dir_d;
  logic               scene_change_q, scene_change_d;

  logic               frozen;
  logic               count_en;
  logic               expire;
  logic               skip_req;
  logic               request;
  logic               frame_start;
  logic               apply_ok;
  logic [SCENE_W-1:0] next_scene;
  logic               next_dir;

  // Advance requests and the window in which they may be applied
  always_comb begin
    frozen      = (bus.mode == MODE_FREEZE);
    count_en    = bus.enable && !frozen;
    expire      = count_en && (cnt_q == CNT_LAST);
    skip_req    = bus.skip && !frozen;
    request     = expire || skip_req;
    // Without frame sync the pixel position is irrelevant
    frame_start = (FRAME_SYNC == 0) || ((bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0));
    apply_ok    = (request || pending_q) && frame_start && !frozen;
  end

  // Scene that the current mode would step to from the present scene
  always_comb begin
    next_scene = state_q;
    next_dir   = dir_q;
    case (bus.mode)
      MODE_WRAP: begin
        next_scene = (state_q == LAST_SCENE) ? FIRST_SCENE : state_q + 1'b1;
      end
      MODE_PING: begin
        if (!dir_q) begin
          if (state_q == LAST_SCENE) begin
            next_scene = state_q - 1'b1;
            next_dir   = 1'b1;
          end else begin
            next_scene = state_q + 1'b1;
          end
        end else begin
          if (state_q == FIRST_SCENE) begin
            next_scene = SCENE_W'(1);
            next_dir   = 1'b0;
          end else begin
            next_scene = state_q - 1'b1;
          end
        end
      end
      MODE_ONESHOT: begin
        // Final scene is sticky: the apply is consumed but nothing moves
        if (state_q != LAST_SCENE) begin
          next_scene = state_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Register next-state: restart overrides skip, skip overrides expiry
  always_comb begin
    cnt_d          = cnt_q;
    state_d        = state_q;
    pending_d      = pending_q;
    dir_d          = dir_q;
    scene_change_d = 1'b0;
    if (bus.restart) begin
      cnt_d     = '0;
      state_d   = RST_SCENE;
      pending_d = 1'b0;
      dir_d     = 1'b0;
    end else begin
      if (skip_req || expire) begin
        cnt_d = '0;
      end else if (count_en) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (apply_ok) begin
        pending_d      = 1'b0;
        state_d        = next_scene;
        dir_d          = next_dir;
        scene_change_d = (next_scene != state_q);
      end else if (request) begin
        pending_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      state_q        <= RST_SCENE;
      pending_q      <= 1'b0;
      dir_q          <= 1'b0;
      scene_change_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      dir_q          <= dir_d;
      scene_change_q <= scene_change_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.scene_change = scene_change_q;
  assign bus.done         = (bus.mode == MODE_ONESHOT) && (state_q == LAST_SCENE);

endmodule
`default_nettype wire

// File: tb/tb_scene_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scene_sequencer
//  Description : Directed bench for scene_sequencer; one instance without
//                frame sync (dut_a) and one with frame sync (dut_b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  scene_sequencer_if #(.SCENE_W(2)) bus_a();
  scene_sequencer_if #(.SCENE_W(2)) bus_b();

  scene_sequencer #(
    .N_SCENES(4), .SCENE_W(2), .PERIOD(4), .CNT_W(3),
    .RESET_SCENE(2), .FRAME_SYNC(0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  scene_sequencer #(
    .N_SCENES(4), .SCENE_W(2), .PERIOD(4), .CNT_W(3),
    .RESET_SCENE(2), .FRAME_SYNC(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic [1:0] wrap_seq [4];
  logic [1:0] ping_seq [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous reset takes effect between clock edges
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus_a.state !== 2'd2) begin miscompares++; $display("FAIL reset_state_a: got %0d expected 2", bus_a.state); end
    vectors++; if (bus_b.state !== 2'd2) begin miscompares++; $display("FAIL reset_state_b: got %0d expected 2", bus_b.state); end
    vectors++; if (bus_a.scene_change !== 1'b0) begin miscompares++; $display("FAIL reset_pulse_a: got %0b expected 0", bus_a.scene_change); end
    vectors++; if (bus_a.done !== 1'b0) begin miscompares++; $display("FAIL reset_done_a: got %0b expected 0", bus_a.done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_s;
    logic       exp_p;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_s = wrap_seq[k/4];
      exp_p = (k % 4 == 0);
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL wrap_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
      vectors++; if (bus_a.scene_change !== exp_p) begin miscompares++; $display("FAIL wrap_pulse k=%0d: got %0b expected %0b", k, bus_a.scene_change, exp_p); end
    end
  endtask

  task automatic test_ping_pong();
    logic [1:0] exp_s;
    logic       exp_p;
    bus_a.mode    = 2'b01;
    bus_a.restart = 1'b1;
    @(negedge clk);
    bus_a.restart = 1'b0;
    vectors++; if (bus_a.state !== 2'd2) begin miscompares++; $display("FAIL ping_restart_state: got %0d expected 2", bus_a.state); end
    vectors++; if (bus_a.scene_change !== 1'b0) begin miscompares++; $display("FAIL ping_restart_pulse: got %0b expected 0", bus_a.scene_change); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_s = ping_seq[k/4];
      exp_p = (k % 4 == 0);
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL ping_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
      vectors++; if (bus_a.scene_change !== exp_p) begin miscompares++; $display("FAIL ping_pulse k=%0d: got %0b expected %0b", k, bus_a.scene_change, exp_p); end
    end
  endtask

  task automatic test_one_shot();
    logic [1:0] exp_s;
    logic       exp_p;
    logic       exp_d;
    bus_a.mode    = 2'b10;
    bus_a.restart = 1'b1;
    @(negedge clk);
    bus_a.restart = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_s = (k >= 4) ? 2'd3 : 2'd2;
      exp_p = (k == 4);
      exp_d = (k >= 4);
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL oneshot_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
      vectors++; if (bus_a.scene_change !== exp_p) begin miscompares++; $display("FAIL oneshot_pulse k=%0d: got %0b expected %0b", k, bus_a.scene_change, exp_p); end
      vectors++; if (bus_a.done !== exp_d) begin miscompares++; $display("FAIL oneshot_done k=%0d: got %0b expected %0b", k, bus_a.done, exp_d); end
    end
    bus_a.restart = 1'b1;
    @(negedge clk);
    bus_a.restart = 1'b0;
    vectors++; if (bus_a.state !== 2'd2) begin miscompares++; $display("FAIL oneshot_restart_state: got %0d expected 2", bus_a.state); end
    vectors++; if (bus_a.done !== 1'b0) begin miscompares++; $display("FAIL oneshot_restart_done: got %0b expected 0", bus_a.done); end
    vectors++; if (bus_a.scene_change !== 1'b0) begin miscompares++; $display("FAIL oneshot_restart_pulse: got %0b expected 0", bus_a.scene_change); end
  endtask

  // Restart wins over skip; then skip alone advances on its own edge
  task automatic test_priority();
    logic [1:0] exp_s;
    logic       exp_p;
    bus_a.mode = 2'b00;
    repeat (2) @(negedge clk);
    bus_a.skip    = 1'b1;
    bus_a.restart = 1'b1;
    @(negedge clk);
    bus_a.skip    = 1'b0;
    bus_a.restart = 1'b0;
    vectors++; if (bus_a.state !== 2'd2) begin miscompares++; $display("FAIL prio_state: got %0d expected 2", bus_a.state); end
    vectors++; if (bus_a.scene_change !== 1'b0) begin miscompares++; $display("FAIL prio_pulse: got %0b expected 0", bus_a.scene_change); end
    vectors++; if (dut_a.cnt_q !== 3'd0) begin miscompares++; $display("FAIL prio_cnt: got %0d expected 0", dut_a.cnt_q); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_s = (k == 4) ? 2'd3 : 2'd2;
      exp_p = (k == 4);
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL prio_period_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
      vectors++; if (bus_a.scene_change !== exp_p) begin miscompares++; $display("FAIL prio_period_pulse k=%0d: got %0b expected %0b", k, bus_a.scene_change, exp_p); end
    end
    bus_a.skip = 1'b1;
    @(negedge clk);
    bus_a.skip = 1'b0;
    vectors++; if (bus_a.state !== 2'd0) begin miscompares++; $display("FAIL skip_state: got %0d expected 0", bus_a.state); end
    vectors++; if (bus_a.scene_change !== 1'b1) begin miscompares++; $display("FAIL skip_pulse: got %0b expected 1", bus_a.scene_change); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_s = (k == 4) ? 2'd1 : 2'd0;
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL skip_period_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
    end
  endtask

  task automatic test_freeze();
    logic [1:0] exp_s;
    logic       exp_p;
    bus_a.mode = 2'b11;
    bus_a.skip = 1'b1;
    @(negedge clk);
    bus_a.skip = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      vectors++; if (bus_a.state !== 2'd1) begin miscompares++; $display("FAIL freeze_state k=%0d: got %0d expected 1", k, bus_a.state); end
      vectors++; if (bus_a.scene_change !== 1'b0) begin miscompares++; $display("FAIL freeze_pulse k=%0d: got %0b expected 0", k, bus_a.scene_change); end
    end
    vectors++; if (dut_a.cnt_q !== 3'd0) begin miscompares++; $display("FAIL freeze_cnt: got %0d expected 0", dut_a.cnt_q); end
    bus_a.mode = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_s = (k == 4) ? 2'd2 : 2'd1;
      exp_p = (k == 4);
      vectors++; if (bus_a.state !== exp_s) begin miscompares++; $display("FAIL unfreeze_state k=%0d: got %0d expected %0d", k, bus_a.state, exp_s); end
      vectors++; if (bus_a.scene_change !== exp_p) begin miscompares++; $display("FAIL unfreeze_pulse k=%0d: got %0b expected %0b", k, bus_a.scene_change, exp_p); end
    end
  endtask

  // Expiries at k=4,8,...; frame starts placed at k=14,22,24,32,37
  task automatic test_frame_sync();
    logic [1:0] exp_s;
    logic       exp_p;
    bus_b.enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k < 14)      exp_s = 2'd2;
      else if (k < 22) exp_s = 2'd3;
      else if (k < 24) exp_s = 2'd0;
      else if (k < 32) exp_s = 2'd1;
      else if (k < 37) exp_s = 2'd2;
      else             exp_s = 2'd3;
      exp_p = (k == 14) || (k == 22) || (k == 24) || (k == 32) || (k == 37);
      vectors++; if (bus_b.state !== exp_s) begin miscompares++; $display("FAIL fsync_state k=%0d: got %0d expected %0d", k, bus_b.state, exp_s); end
      vectors++; if (bus_b.scene_change !== exp_p) begin miscompares++; $display("FAIL fsync_pulse k=%0d: got %0b expected %0b", k, bus_b.scene_change, exp_p); end
      if (k == 4) begin
        vectors++; if (dut_b.pending_q !== 1'b1) begin miscompares++; $display("FAIL fsync_pending k=4: got %0b expected 1", dut_b.pending_q); end
      end
      // Drive the pixel position for the next edge
      if (k == 13 || k == 21 || k == 23 || k == 31 || k == 36) begin
        bus_b.h_cnt = 10'd0;
        bus_b.v_cnt = 10'd0;
      end else begin
        bus_b.h_cnt = 10'd5;
        bus_b.v_cnt = 10'd0;
      end
      if (k == 28) bus_b.enable = 1'b0;
      if (k == 32) bus_b.enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp_s;
    logic       exp_p;
    vectors++; if (dut_b.pending_q !== 1'b1) begin miscompares++; $display("FAIL areset_pre_pending: got %0b expected 1", dut_b.pending_q); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus_b.state !== 2'd2) begin miscompares++; $display("FAIL areset_state: got %0d expected 2", bus_b.state); end
    vectors++; if (dut_b.pending_q !== 1'b0) begin miscompares++; $display("FAIL areset_pending: got %0b expected 0", dut_b.pending_q); end
    vectors++; if (dut_b.cnt_q !== 3'd0) begin miscompares++; $display("FAIL areset_cnt: got %0d expected 0", dut_b.cnt_q); end
    @(negedge clk);
    rst = 1'b0;
    bus_b.h_cnt = 10'd0;
    bus_b.v_cnt = 10'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_s = (k == 4) ? 2'd3 : 2'd2;
      exp_p = (k == 4);
      vectors++; if (bus_b.state !== exp_s) begin miscompares++; $display("FAIL areset_period_state k=%0d: got %0d expected %0d", k, bus_b.state, exp_s); end
      vectors++; if (bus_b.scene_change !== exp_p) begin miscompares++; $display("FAIL areset_period_pulse k=%0d: got %0b expected %0b", k, bus_b.scene_change, exp_p); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wrap_seq[0] = 2'd2; wrap_seq[1] = 2'd3; wrap_seq[2] = 2'd0; wrap_seq[3] = 2'd1;
    ping_seq[0] = 2'd2; ping_seq[1] = 2'd3; ping_seq[2] = 2'd2;
    ping_seq[3] = 2'd1; ping_seq[4] = 2'd0; ping_seq[5] = 2'd1;
    rst           = 1'b0;
    bus_a.h_cnt   = 10'd0;
    bus_a.v_cnt   = 10'd0;
    bus_a.enable  = 1'b1;
    bus_a.mode    = 2'b00;
    bus_a.skip    = 1'b0;
    bus_a.restart = 1'b0;
    bus_b.h_cnt   = 10'd5;
    bus_b.v_cnt   = 10'd0;
    bus_b.enable  = 1'b0;
    bus_b.mode    = 2'b00;
    bus_b.skip    = 1'b0;
    bus_b.restart = 1'b0;

    test_reset();
    test_wrap();
    test_ping_pong();
    test_one_shot();
    test_priority();
    test_freeze();
    test_frame_sync();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
